// File: rtl/burrito_pkg.sv
// -----------------------------------------------------------------------------
// burrito_pkg
// Shared definitions for the Burrito program loader / fetch sequencer:
//   - INSTR_W      : instruction word width
//   - *_BIT/*_HI/*_LO : bit positions of the datapath control fields
//   - state_t      : sequencer FSM states
// No ports (package).
// -----------------------------------------------------------------------------
package burrito_pkg;

    localparam int INSTR_W = 20;

    // Field layout of an instruction word: WE | OP | D1 | D2 | RD
    localparam int WE_BIT = 19;
    localparam int OP_HI  = 18;
    localparam int OP_LO  = 15;
    localparam int D1_HI  = 14;
    localparam int D1_LO  = 10;
    localparam int D2_HI  = 9;
    localparam int D2_LO  = 5;
    localparam int RD_HI  = 4;
    localparam int RD_LO  = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,  // no program loaded
        ST_LOAD  = 3'd1,  // receiving program words
        ST_READY = 3'd2,  // program held, waiting for start
        ST_RUN   = 3'd3,  // presenting instructions to the datapath
        ST_DONE  = 3'd4   // program completed
    } state_t;

endpackage

// File: rtl/burrito_decode.sv
// -----------------------------------------------------------------------------
// burrito_decode
// Purely combinational split of one instruction word into the Burrito
// datapath control fields.
// Ports:
//   word     in  INSTR_W  instruction word
//   w_enable out 1        register write enable
//   op       out 4        ALU opcode
//   d1       out 5        source register 1
//   d2       out 5        source register 2
//   rd       out 5        destination register
// -----------------------------------------------------------------------------
module burrito_decode
    import burrito_pkg::*;
(
    input  logic [INSTR_W-1:0] word,
    output logic               w_enable,
    output logic [3:0]         op,
    output logic [4:0]         d1,
    output logic [4:0]         d2,
    output logic [4:0]         rd
);

    assign w_enable = word[WE_BIT];
    assign op       = word[OP_HI:OP_LO];
    assign d1       = word[D1_HI:D1_LO];
    assign d2       = word[D2_HI:D2_LO];
    assign rd       = word[RD_HI:RD_LO];

endmodule

// File: rtl/burrito_sequencer.sv
// -----------------------------------------------------------------------------
// burrito_sequencer
// Program loader and instruction fetch sequencer for the Burrito datapath.
// Words arriving on the valid/ready load port are written sequentially into
// an external asynchronous-read RAM. On start the program is read back in
// address order, decoded and presented to the datapath one instruction per
// HOLD cycles.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   load_valid/data/last, load_ready   program load handshake
//   start             single-cycle run request (READY or DONE only)
//   mem_we/addr/din   RAM write port and shared address
//   mem_dout          RAM combinational read data
//   WEnable/Op/D1/D2/RD  registered datapath control fields
//   instr_valid       fields carry a live instruction
//   busy              sequencer is running
//   done              program completed, held until start or rst
// -----------------------------------------------------------------------------
module burrito_sequencer
    import burrito_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 6,
    parameter int HOLD   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    input  logic               start,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_din,
    input  logic [INSTR_W-1:0] mem_dout,
    output logic               WEnable,
    output logic [3:0]         Op,
    output logic [4:0]         D1,
    output logic [4:0]         D2,
    output logic [4:0]         RD,
    output logic               instr_valid,
    output logic               busy,
    output logic               done
);

    // One extra bit so pointers and lengths can represent DEPTH itself.
    localparam int PTR_W = ADDR_W + 1;
    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [PTR_W-1:0]    pc_q, pc_d;
    logic [PTR_W-1:0]    prog_len_q, prog_len_d;
    logic [CNT_W-1:0]    hold_q, hold_d;

    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [INSTR_W-1:0]  wdata_q, wdata_d;

    logic                wen_q, wen_d;
    logic [3:0]          op_q, op_d;
    logic [4:0]          d1_q, d1_d;
    logic [4:0]          d2_q, d2_d;
    logic [4:0]          rd_q, rd_d;
    logic                vld_q, vld_d;

    logic                dec_we;
    logic [3:0]          dec_op;
    logic [4:0]          dec_d1;
    logic [4:0]          dec_d2;
    logic [4:0]          dec_rd;
    logic                accept;

    burrito_decode u_decode (
        .word     (mem_dout),
        .w_enable (dec_we),
        .op       (dec_op),
        .d1       (dec_d1),
        .d2       (dec_d2),
        .rd       (dec_rd)
    );

    assign load_ready = ((state_q == ST_IDLE) || (state_q == ST_LOAD)) &&
                        (wptr_q < PTR_W'(DEPTH));
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        pc_d       = pc_q;
        prog_len_d = prog_len_q;
        hold_d     = hold_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wen_d      = wen_q;
        op_d       = op_q;
        d1_d       = d1_q;
        d2_d       = d2_q;
        rd_d       = rd_q;
        vld_d      = vld_q;

        unique case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    // Write is registered: presented to the RAM the cycle
                    // after the handshake.
                    we_d    = 1'b1;
                    waddr_d = wptr_q[ADDR_W-1:0];
                    wdata_d = load_data;
                    wptr_d  = wptr_q + 1'b1;
                    if (load_last || (wptr_q == PTR_W'(DEPTH - 1))) begin
                        state_d    = ST_READY;
                        prog_len_d = wptr_q + 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_READY, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    hold_d  = '0;
                end
            end

            ST_RUN: begin
                if (hold_q == '0) begin
                    if (pc_q == prog_len_q) begin
                        state_d = ST_DONE;
                        wen_d   = 1'b0;
                        op_d    = '0;
                        d1_d    = '0;
                        d2_d    = '0;
                        rd_d    = '0;
                        vld_d   = 1'b0;
                    end else begin
                        // Capture the word at pc and move the address on
                        // immediately; the RAM has the whole hold period to
                        // settle on the next word.
                        wen_d  = dec_we;
                        op_d   = dec_op;
                        d1_d   = dec_d1;
                        d2_d   = dec_d2;
                        rd_d   = dec_rd;
                        vld_d  = 1'b1;
                        pc_d   = pc_q + 1'b1;
                        hold_d = CNT_W'(HOLD - 1);
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            pc_q       <= '0;
            prog_len_q <= '0;
            hold_q     <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
            op_q       <= '0;
            d1_q       <= '0;
            d2_q       <= '0;
            rd_q       <= '0;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            pc_q       <= pc_d;
            prog_len_q <= prog_len_d;
            hold_q     <= hold_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wen_q      <= wen_d;
            op_q       <= op_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            rd_q       <= rd_d;
            vld_q      <= vld_d;
        end
    end

    // The RAM address is shared: fetch address while running, otherwise the
    // address of the most recent load write.
    assign mem_addr    = (state_q == ST_RUN) ? pc_q[ADDR_W-1:0] : waddr_q;
    assign mem_we      = we_q;
    assign mem_din     = wdata_q;
    assign WEnable     = wen_q;
    assign Op          = op_q;
    assign D1          = d1_q;
    assign D2          = d2_q;
    assign RD          = rd_q;
    assign instr_valid = vld_q;
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_burrito_sequencer.sv
module tb_burrito_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Two instances: index 0 has HOLD=1, index 1 has HOLD=3.
    logic        rst_s        [2];
    logic        load_valid_s [2];
    logic [19:0] load_data_s  [2];
    logic        load_last_s  [2];
    logic        start_s      [2];
    logic        load_ready_s [2];
    logic        mem_we_s     [2];
    logic [2:0]  mem_addr_s   [2];
    logic [19:0] mem_din_s    [2];
    logic [19:0] mem_dout_s   [2];
    logic        wen_s        [2];
    logic [3:0]  op_s         [2];
    logic [4:0]  d1_s         [2];
    logic [4:0]  d2_s         [2];
    logic [4:0]  rd_s         [2];
    logic        ivld_s       [2];
    logic        busy_s       [2];
    logic        done_s       [2];

    burrito_sequencer #(.ADDR_W(3), .DEPTH(6), .HOLD(1)) u_dut (
        .clk(clk), .rst(rst_s[0]),
        .load_valid(load_valid_s[0]), .load_data(load_data_s[0]),
        .load_last(load_last_s[0]), .load_ready(load_ready_s[0]),
        .start(start_s[0]),
        .mem_we(mem_we_s[0]), .mem_addr(mem_addr_s[0]),
        .mem_din(mem_din_s[0]), .mem_dout(mem_dout_s[0]),
        .WEnable(wen_s[0]), .Op(op_s[0]), .D1(d1_s[0]), .D2(d2_s[0]), .RD(rd_s[0]),
        .instr_valid(ivld_s[0]), .busy(busy_s[0]), .done(done_s[0])
    );

    burrito_sequencer #(.ADDR_W(3), .DEPTH(6), .HOLD(3)) u_dut_h3 (
        .clk(clk), .rst(rst_s[1]),
        .load_valid(load_valid_s[1]), .load_data(load_data_s[1]),
        .load_last(load_last_s[1]), .load_ready(load_ready_s[1]),
        .start(start_s[1]),
        .mem_we(mem_we_s[1]), .mem_addr(mem_addr_s[1]),
        .mem_din(mem_din_s[1]), .mem_dout(mem_dout_s[1]),
        .WEnable(wen_s[1]), .Op(op_s[1]), .D1(d1_s[1]), .D2(d2_s[1]), .RD(rd_s[1]),
        .instr_valid(ivld_s[1]), .busy(busy_s[1]), .done(done_s[1])
    );

    // Asynchronous-read instruction RAM per instance.
    for (genvar g = 0; g < 2; g++) begin : g_ram
        logic [19:0] ram [8];
        always @(posedge clk) begin
            if (mem_we_s[g]) ram[mem_addr_s[g]] <= mem_din_s[g];
        end
        assign mem_dout_s[g] = ram[mem_addr_s[g]];
    end

    // Reference model: the program each instance should hold.
    logic [19:0] prog [2][8];
    int          plen [2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic reset_chk(input int i);
        rst_s[i] = 1'b1;
        @(negedge clk);
        rst_s[i] = 1'b0;
        chk("rst_load_ready", load_ready_s[i], 1);
        chk("rst_mem_we",     mem_we_s[i], 0);
        chk("rst_mem_addr",   mem_addr_s[i], 0);
        chk("rst_mem_din",    mem_din_s[i], 0);
        chk("rst_wen",        wen_s[i], 0);
        chk("rst_fields",     {op_s[i], d1_s[i], d2_s[i], rd_s[i]}, 0);
        chk("rst_vld",        ivld_s[i], 0);
        chk("rst_busy",       busy_s[i], 0);
        chk("rst_done",       done_s[i], 0);
    endtask

    // Offer n words; with use_last the final one carries load_last, otherwise
    // the loader must close the program by itself at DEPTH words.
    task automatic load_prog(input int i, input int n, input bit use_last,
                             input bit fixed_first, input bit gaps);
        int k = 0;
        logic [19:0] w;
        while (k < n) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                load_valid_s[i] = 1'b0;
                @(negedge clk);
                chk("ld_gap_we", mem_we_s[i], 0);
            end else begin
                chk("ld_ready", load_ready_s[i], 1);
                w = (fixed_first && k == 0) ? 20'h91234 : 20'($urandom);
                load_valid_s[i] = 1'b1;
                load_data_s[i]  = w;
                load_last_s[i]  = use_last && (k == n - 1);
                @(negedge clk);
                chk("ld_we",   mem_we_s[i], 1);
                chk("ld_addr", mem_addr_s[i], k);
                chk("ld_din",  mem_din_s[i], w);
                prog[i][k] = w;
                k++;
            end
        end
        plen[i] = n;
        // A further word must be refused once the program is held.
        load_valid_s[i] = 1'b1;
        load_last_s[i]  = 1'b0;
        load_data_s[i]  = 20'($urandom);
        chk("ld_ready_held", load_ready_s[i], 0);
        @(negedge clk);
        chk("ld_refused_we", mem_we_s[i], 0);
        chk("ld_refused_busy", busy_s[i], 0);
        load_valid_s[i] = 1'b0;
    endtask

    task automatic chk_instr(input int i, input logic [19:0] w);
        int wi;
        wi = int'(w);
        chk("run_vld", ivld_s[i], 1);
        chk("run_wen", wen_s[i], (wi >> 19) & 1);
        chk("run_op",  op_s[i],  (wi >> 15) & 15);
        chk("run_d1",  d1_s[i],  (wi >> 10) & 31);
        chk("run_d2",  d2_s[i],  (wi >> 5) & 31);
        chk("run_rd",  rd_s[i],  wi & 31);
    endtask

    // Instruction k is presented after edges S+1+k*h .. S+(k+1)*h; done
    // after edge S+1+len*h. Optional disturbance: load offers and start pulses.
    task automatic run_prog(input int i, input int h, input bit disturb);
        int total;
        total = plen[i] * h;
        start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
        chk("run_busy0", busy_s[i], 1);
        chk("run_addr0", mem_addr_s[i], 0);
        chk("run_vld0",  ivld_s[i], 0);
        chk("run_done0", done_s[i], 0);
        for (int j = 1; j <= total + 1; j++) begin
            if (disturb) begin
                load_valid_s[i] = 1'b1;
                load_data_s[i]  = 20'($urandom);
                start_s[i]      = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            chk("run_mem_we", mem_we_s[i], 0);
            if (disturb) chk("run_load_ready", load_ready_s[i], 0);
            if (j <= total) begin
                chk_instr(i, prog[i][(j - 1) / h]);
                chk("run_busy", busy_s[i], 1);
                chk("run_done", done_s[i], 0);
            end else begin
                chk("end_done",   done_s[i], 1);
                chk("end_vld",    ivld_s[i], 0);
                chk("end_wen",    wen_s[i], 0);
                chk("end_fields", {op_s[i], d1_s[i], d2_s[i], rd_s[i]}, 0);
                chk("end_busy",   busy_s[i], 0);
            end
        end
        start_s[i]      = 1'b0;
        load_valid_s[i] = 1'b0;
        @(negedge clk);
        chk("done_hold", done_s[i], 1);
        chk("done_busy", busy_s[i], 0);
    endtask

    // Reset while instruction 2 is presented; later start must be ignored.
    task automatic rst_mid_run(input int i, input int h);
        start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
        for (int j = 1; j <= 2 * h + 1; j++) @(negedge clk);
        chk_instr(i, prog[i][2]);
        rst_s[i] = 1'b1;
        @(negedge clk);
        rst_s[i] = 1'b0;
        chk("mid_rst_wen",   wen_s[i], 0);
        chk("mid_rst_vld",   ivld_s[i], 0);
        chk("mid_rst_busy",  busy_s[i], 0);
        chk("mid_rst_done",  done_s[i], 0);
        chk("mid_rst_ready", load_ready_s[i], 1);
        start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("ign_start_busy", busy_s[i], 0);
            chk("ign_start_vld",  ivld_s[i], 0);
            chk("ign_start_wen",  wen_s[i], 0);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit ul;
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b1; load_valid_s[i] = 1'b0; load_data_s[i] = '0;
            load_last_s[i] = 1'b0; start_s[i] = 1'b0; plen[i] = 0;
        end
        @(negedge clk);
        @(negedge clk);
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;

        // HOLD = 1 instance
        reset_chk(0);
        load_prog(0, 6, 1'b1, 1'b1, 1'b0);
        run_prog(0, 1, 1'b0);
        run_prog(0, 1, 1'b1);            // replay from DONE, disturbed
        for (int it = 0; it < 4; it++) begin
            reset_chk(0);
            n  = int'($urandom_range(1, 6));
            ul = (n < 6) ? 1'b1 : 1'($urandom_range(0, 1));
            load_prog(0, n, ul, 1'b0, 1'b1);
            run_prog(0, 1, 1'(it & 1));
        end
        reset_chk(0);
        load_prog(0, 6, 1'b0, 1'b0, 1'b0);   // closes at DEPTH without load_last
        rst_mid_run(0, 1);
        load_prog(0, 4, 1'b1, 1'b0, 1'b0);
        run_prog(0, 1, 1'b0);

        // HOLD = 3 instance
        reset_chk(1);
        load_prog(1, 1, 1'b1, 1'b0, 1'b0);   // 1-word program
        run_prog(1, 3, 1'b0);
        run_prog(1, 3, 1'b1);
        reset_chk(1);
        n = int'($urandom_range(2, 6));
        load_prog(1, n, 1'b1, 1'b1, 1'b1);
        run_prog(1, 3, 1'b1);
        reset_chk(1);
        load_prog(1, 5, 1'b1, 1'b0, 1'b0);
        rst_mid_run(1, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
